// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC pre-rotation stage: the mode encoding,
// the quadrant-fold operation selector, and the binary-angle constants
// (2^(w-1) LSB represents pi).
package cordic_pkg;

  // Operating mode as carried with each sample.
  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  // Fold applied by the pre-stage to bring the vector/angle into
  // the right half-plane where the CORDIC iterations converge.
  typedef enum logic [1:0] {
    OP_PASS = 2'd0,  // no change (or vectoring with X >= 0)
    OP_FLIP = 2'd1,  // vectoring, X < 0: rotate by pi
    OP_CW   = 2'd2,  // rotation, theta > +pi/2: pre-rotate by +pi/2
    OP_CCW  = 2'd3   // rotation, theta < -pi/2: pre-rotate by -pi/2
  } prestage_op_e;

  // Binary angle of pi for a w-bit angle word. Truncated to w bits this
  // is the 100..0 pattern, which is both +pi and -pi.
  function automatic logic [31:0] ANGLE_PI(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Binary angle of pi/2 for a w-bit angle word.
  function automatic logic [31:0] ANGLE_HALF_PI(input int unsigned w);
    return 32'd1 << (w - 2);
  endfunction

endpackage

// File: rtl/cordic_neg.sv
// Combinational two's-complement negation of one operand.
// Build option CORDIC_PRESTAGE_SAT_EN: when defined, negating the most
// negative value saturates to the most positive value and raises sat_o;
// when undefined, the result wraps back to the most negative value and
// there is no sat_o port.
module cordic_neg #(
  parameter int W = 15
) (
  input  logic signed [W-1:0] a_i,
`ifdef CORDIC_PRESTAGE_SAT_EN
  output logic                sat_o,
`endif
  output logic signed [W-1:0] neg_o
);

`ifdef CORDIC_PRESTAGE_SAT_EN
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

  // Saturating negate: -MIN does not fit, clamp to MAX and flag it.
  always_comb begin
    sat_o = 1'b0;
    neg_o = -a_i;
    if (a_i == MIN_V) begin
      sat_o = 1'b1;
      neg_o = MAX_V;
    end
  end
`else
  // Plain two's-complement negate; -MIN wraps to MIN.
  always_comb begin
    neg_o = -a_i;
  end
`endif

endmodule

// File: rtl/cordic_prestage.sv
// CORDIC pre-rotation stage: folds the input vector/angle into the
// convergence range of the CORDIC iterations, one registered stage.
//   vectoring: X < 0 -> rotate by pi (negate X and Y, angle = pi)
//   rotation : theta beyond +/-pi/2 -> pre-rotate by +/-pi/2
// Build option CORDIC_PRESTAGE_SAT_EN selects saturating negation and
// adds the sticky sat_flag output.
//
// Handshake: a sample transfers on a rising edge when in_valid && in_ready.
// in_ready = !out_valid || out_ready, so the stage streams one sample per
// cycle; while out_valid && !out_ready every output holds stable, and an
// accept-out together with accept-in replaces the output on the same edge.
module cordic_prestage
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH  = 15,
  parameter int ANGLE_WIDTH = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic signed [DATA_WIDTH-1:0]  X_in,
  input  logic signed [DATA_WIDTH-1:0]  Y_in,
  input  logic signed [ANGLE_WIDTH-1:0] theta_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  X_out,
  output logic signed [DATA_WIDTH-1:0]  Y_out,
  output logic signed [ANGLE_WIDTH-1:0] theta_out,
`ifdef CORDIC_PRESTAGE_SAT_EN
  output logic                          sat_flag,
`endif
  output logic                          mode_out
);

  localparam logic signed [ANGLE_WIDTH-1:0] PI_A      = ANGLE_WIDTH'(ANGLE_PI(ANGLE_WIDTH));
  localparam logic signed [ANGLE_WIDTH-1:0] HALF_PI_A = ANGLE_WIDTH'(ANGLE_HALF_PI(ANGLE_WIDTH));
  localparam logic signed [ANGLE_WIDTH-1:0] NEG_HALF_PI_A = -HALF_PI_A;

  cordic_mode_e                  mode_e;
  prestage_op_e                  op;
  logic                          take;

  logic signed [DATA_WIDTH-1:0]  neg_x;
  logic signed [DATA_WIDTH-1:0]  neg_y;

  logic signed [DATA_WIDTH-1:0]  x_d, x_q;
  logic signed [DATA_WIDTH-1:0]  y_d, y_q;
  logic signed [ANGLE_WIDTH-1:0] theta_d, theta_q;
  cordic_mode_e                  mode_q;
  logic                          out_valid_q;

  assign mode_e   = cordic_mode_e'(mode);
  assign in_ready = !out_valid_q || out_ready;
  assign take     = in_valid && in_ready;

`ifdef CORDIC_PRESTAGE_SAT_EN
  logic negx_sat;
  logic negy_sat;
  logic sat_hit;
  logic sat_q;

  cordic_neg #(.W(DATA_WIDTH)) u_neg_x (.a_i(X_in), .sat_o(negx_sat), .neg_o(neg_x));
  cordic_neg #(.W(DATA_WIDTH)) u_neg_y (.a_i(Y_in), .sat_o(negy_sat), .neg_o(neg_y));

  // A saturation only counts when the saturated negation is the one selected.
  always_comb begin
    sat_hit = 1'b0;
    case (op)
      OP_FLIP: sat_hit = negx_sat || negy_sat;
      OP_CW:   sat_hit = negy_sat;
      OP_CCW:  sat_hit = negx_sat;
      default: sat_hit = 1'b0;
    endcase
  end

  // Sticky saturation flag, set by an accepted saturating sample, cleared by reset only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (take && sat_hit) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  cordic_neg #(.W(DATA_WIDTH)) u_neg_x (.a_i(X_in), .neg_o(neg_x));
  cordic_neg #(.W(DATA_WIDTH)) u_neg_y (.a_i(Y_in), .neg_o(neg_y));
`endif

  // Pick the fold; the +/-pi/2 boundaries themselves pass through unchanged.
  always_comb begin
    op = OP_PASS;
    if (mode_e == MODE_VEC) begin
      if (X_in[DATA_WIDTH-1]) op = OP_FLIP;
    end else begin
      if (theta_in > HALF_PI_A)          op = OP_CW;
      else if (theta_in < NEG_HALF_PI_A) op = OP_CCW;
    end
  end

  // Apply the fold; angle arithmetic wraps modulo 2^ANGLE_WIDTH.
  always_comb begin
    x_d     = X_in;
    y_d     = Y_in;
    theta_d = theta_in;
    case (op)
      OP_PASS: begin
        // Vectoring accumulates angle from zero.
        if (mode_e == MODE_VEC) theta_d = '0;
      end
      OP_FLIP: begin
        x_d     = neg_x;
        y_d     = neg_y;
        theta_d = PI_A;
      end
      OP_CW: begin
        x_d     = neg_y;
        y_d     = X_in;
        theta_d = theta_in - HALF_PI_A;
      end
      OP_CCW: begin
        x_d     = Y_in;
        y_d     = neg_x;
        theta_d = theta_in + HALF_PI_A;
      end
      default: begin
        x_d     = X_in;
        y_d     = Y_in;
        theta_d = theta_in;
      end
    endcase
  end

  // Output register: load on transfer, drop valid once consumed, clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      theta_q     <= '0;
      mode_q      <= MODE_ROT;
    end else if (take) begin
      out_valid_q <= 1'b1;
      x_q         <= x_d;
      y_q         <= y_d;
      theta_q     <= theta_d;
      mode_q      <= mode_e;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign X_out     = x_q;
  assign Y_out     = y_q;
  assign theta_out = theta_q;
  assign mode_out  = mode_q;

endmodule

// File: doc/cordic_prestage.md
CORDIC_PRESTAGE -- requirements
Module: cordic_prestage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 15: signed width of X/Y datapath.
REQ-002 The block SHALL have parameter ANGLE_WIDTH, default 15: signed binary-angle width; 2^(ANGLE_WIDTH-1) LSB = pi.
REQ-003 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1: input sample valid.
REQ-006 The block SHALL have port in_ready, output, 1: block accepts the sample this cycle.
REQ-007 The block SHALL have port mode, input, 1: 0 = rotation, 1 = vectoring; sampled with the input.
REQ-008 The block SHALL have ports X_in and Y_in, input, DATA_WIDTH, signed: input vector.
REQ-009 The block SHALL have port theta_in, input, ANGLE_WIDTH, signed: target angle, rotation mode only.
REQ-010 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1: output handshake.
REQ-011 The block SHALL have ports X_out and Y_out, output, DATA_WIDTH, signed, and theta_out, output, ANGLE_WIDTH, signed: pre-rotated vector and residual/accumulated angle.
REQ-012 The block SHALL have port mode_out, output, 1: mode forwarded with the sample.

Function
REQ-013 A transfer SHALL occur on a clock edge when in_valid and in_ready are both high; latency SHALL be 1 cycle to out_valid.
REQ-014 in_ready SHALL equal (!out_valid || out_ready), so full throughput is sustained and an unaccepted output is held stable.
REQ-015 While out_valid is high and out_ready is low, all outputs SHALL hold; simultaneous accept-in/accept-out SHALL replace the output in the same edge.
REQ-016 Vectoring with X_in >= 0: X_out=X_in, Y_out=Y_in, theta_out=0.
REQ-017 Vectoring with X_in < 0: X_out=-X_in, Y_out=-Y_in, theta_out=2^(ANGLE_WIDTH-1) pattern (pi == -pi, wraps).
REQ-018 Rotation with theta_in > 2^(ANGLE_WIDTH-2) (beyond +pi/2): X_out=-Y_in, Y_out=X_in, theta_out=theta_in-2^(ANGLE_WIDTH-2).
REQ-019 Rotation with theta_in < -2^(ANGLE_WIDTH-2): X_out=Y_in, Y_out=-X_in, theta_out=theta_in+2^(ANGLE_WIDTH-2).
REQ-020 Rotation with |theta_in| <= pi/2 exactly: pass X, Y, theta unchanged (boundaries +/-pi/2 are pass-through).
REQ-021 Negation of the most-negative value -2^(DATA_WIDTH-1) SHALL follow REQ-027.
REQ-022 Angle arithmetic SHALL be modulo 2^ANGLE_WIDTH; no angle saturation.

Reset
REQ-023 On rst high, asynchronously: out_valid=0, X_out=0, Y_out=0, theta_out=0, mode_out=0.
REQ-024 in_ready SHALL be 1 during and after reset (out_valid low).
REQ-025 Reset mid-transfer SHALL discard the held sample; no output for it after release.

Configuration
REQ-026 Macro CORDIC_PRESTAGE_SAT_EN SHALL select negation behaviour.
REQ-027 Defined: negating -2^(DATA_WIDTH-1) yields +2^(DATA_WIDTH-1)-1 and sets sticky output sat_flag (1 bit, cleared only by rst). Undefined: two's-complement wrap (result -2^(DATA_WIDTH-1)); sat_flag port absent.

Structure
REQ-028 Package cordic_pkg SHALL hold the mode encoding (MODE_ROT=0, MODE_VEC=1) and angle constant functions ANGLE_PI and ANGLE_HALF_PI of ANGLE_WIDTH.
REQ-029 Sub-module cordic_neg SHALL implement combinational negation per REQ-027, instantiated per negated operand.

Verification (DATA_WIDTH=15, ANGLE_WIDTH=15; pi=16384 LSB)
REQ-030 Vectoring X=-1000,Y=500 -> next cycle X_out=1000,Y_out=-500,theta_out=-16384, out_valid=1.
REQ-031 Rotation X=100,Y=200,theta=12000 -> X_out=-200,Y_out=100,theta_out=3808; theta=-12000 -> X_out=200,Y_out=-100,theta_out=-3808; theta=8192 -> pass-through.
REQ-032 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no sample lost or duplicated; continuous stream at out_ready=1 -> one output per cycle.
REQ-033 Vectoring X=-16384 -> with macro X_out=16383, sat_flag=1; without macro X_out=-16384.
REQ-034 Assert rst while out_valid=1 and out_ready=0 -> all outputs 0 immediately, out_valid stays 0 after release until a new transfer.
